// File: rtl/axis_seq_checker.sv
// AXI-Stream sink for an incrementing-counter test stream: generates a tready
// backpressure pattern, checks each accepted word is previous+1 and keeps statistics.
module axis_seq_checker #(
  parameter int TDATA_BITS   = 32,
  parameter int CNT_BITS     = 32,
  parameter int READY_MODE   = 0,
  parameter int READY_PERIOD = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  clr,
  input  logic [TDATA_BITS-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  locked,
  output logic [CNT_BITS-1:0]   beat_count,
  output logic [CNT_BITS-1:0]   err_count,
  output logic                  err_flag,
  output logic [TDATA_BITS-1:0] first_err_exp,
  output logic [TDATA_BITS-1:0] first_err_got
);

  localparam int PW = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;

  typedef enum logic {SYNC, LOCKED} state_t;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  logic [1:0]            rst_sync;
  logic                  run;
  logic [15:0]           lfsr, lfsr_nxt;
  logic [PW-1:0]         per_cnt, per_nxt;
  logic                  rdy_nxt;
  logic                  accept;
  state_t                state_q, state_nxt;
  logic [TDATA_BITS-1:0] exp_q, exp_nxt;
  logic [CNT_BITS-1:0]   beat_nxt, err_nxt;
  logic                  flag_nxt;
  logic [TDATA_BITS-1:0] fexp_nxt, fgot_nxt;

  // Reset is asserted asynchronously but released only after two clean edges
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  always_comb begin
    lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    per_nxt  = (per_cnt == PW'(READY_PERIOD - 1)) ? '0 : per_cnt + PW'(1);
    case (READY_MODE)
      1:       rdy_nxt = lfsr_nxt[0];
      2:       rdy_nxt = (per_nxt == '0);
      default: rdy_nxt = 1'b1;
    endcase
  end

  // tready pattern free-runs independently of traffic and of clr
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr          <= 16'hACE1;
      per_cnt       <= '0;
      s_axis_tready <= 1'b0;
    end else if (run) begin
      lfsr          <= lfsr_nxt;
      per_cnt       <= per_nxt;
      s_axis_tready <= rdy_nxt;
    end
  end

  assign accept = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_nxt = state_q;
    exp_nxt   = exp_q;
    beat_nxt  = beat_count;
    err_nxt   = err_count;
    flag_nxt  = err_flag;
    fexp_nxt  = first_err_exp;
    fgot_nxt  = first_err_got;
    if (clr) begin
      state_nxt = SYNC;
      beat_nxt  = '0;
      err_nxt   = '0;
      flag_nxt  = 1'b0;
      fexp_nxt  = '0;
      fgot_nxt  = '0;
    end else if (accept) begin
      beat_nxt = sat_inc(beat_count);
      // On a match tdata+1 equals exp+1, so one expression covers match and resync
      exp_nxt  = s_axis_tdata + TDATA_BITS'(1);
      case (state_q)
        SYNC: state_nxt = LOCKED;
        LOCKED: begin
          if (s_axis_tdata != exp_q) begin
            err_nxt  = sat_inc(err_count);
            flag_nxt = 1'b1;
            if (!err_flag) begin
              fexp_nxt = exp_q;
              fgot_nxt = s_axis_tdata;
            end
          end
        end
        default: state_nxt = SYNC;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= SYNC;
      exp_q         <= '0;
      beat_count    <= '0;
      err_count     <= '0;
      err_flag      <= 1'b0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else begin
      state_q       <= state_nxt;
      exp_q         <= exp_nxt;
      beat_count    <= beat_nxt;
      err_count     <= err_nxt;
      err_flag      <= flag_nxt;
      first_err_exp <= fexp_nxt;
      first_err_got <= fgot_nxt;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_axis_seq_checker.sv
// Bench for axis_seq_checker: four instances (mode0 32b, mode0 8b, mode2, mode1)
// driven by a handshake task, with a per-beat scoreboard of expected statistics.
module tb_axis_seq_checker;

  logic aclk = 1'b0;
  logic aresetn;
  logic clr;
  always #5 aclk = ~aclk;

  logic [31:0] tdata  [4];
  logic        tvalid [4];
  wire         tready [4];
  wire         lck    [4];
  wire         flag   [4];
  wire  [31:0] beat   [4];
  wire  [31:0] errc   [4];
  wire  [31:0] fexp   [4];
  wire  [31:0] fgot   [4];
  wire  [7:0]  fexp8, fgot8;

  assign fexp[1] = {24'h0, fexp8};
  assign fgot[1] = {24'h0, fgot8};

  axis_seq_checker #(.TDATA_BITS(32), .CNT_BITS(32), .READY_MODE(0), .READY_PERIOD(4)) u0 (
    .aclk(aclk), .aresetn(aresetn), .clr(clr), .s_axis_tdata(tdata[0]), .s_axis_tvalid(tvalid[0]),
    .s_axis_tready(tready[0]), .locked(lck[0]), .beat_count(beat[0]), .err_count(errc[0]),
    .err_flag(flag[0]), .first_err_exp(fexp[0]), .first_err_got(fgot[0]));

  axis_seq_checker #(.TDATA_BITS(8), .CNT_BITS(32), .READY_MODE(0), .READY_PERIOD(4)) u1 (
    .aclk(aclk), .aresetn(aresetn), .clr(clr), .s_axis_tdata(tdata[1][7:0]), .s_axis_tvalid(tvalid[1]),
    .s_axis_tready(tready[1]), .locked(lck[1]), .beat_count(beat[1]), .err_count(errc[1]),
    .err_flag(flag[1]), .first_err_exp(fexp8), .first_err_got(fgot8));

  axis_seq_checker #(.TDATA_BITS(32), .CNT_BITS(32), .READY_MODE(2), .READY_PERIOD(4)) u2 (
    .aclk(aclk), .aresetn(aresetn), .clr(clr), .s_axis_tdata(tdata[2]), .s_axis_tvalid(tvalid[2]),
    .s_axis_tready(tready[2]), .locked(lck[2]), .beat_count(beat[2]), .err_count(errc[2]),
    .err_flag(flag[2]), .first_err_exp(fexp[2]), .first_err_got(fgot[2]));

  axis_seq_checker #(.TDATA_BITS(32), .CNT_BITS(32), .READY_MODE(1), .READY_PERIOD(4)) u3 (
    .aclk(aclk), .aresetn(aresetn), .clr(clr), .s_axis_tdata(tdata[3]), .s_axis_tvalid(tvalid[3]),
    .s_axis_tready(tready[3]), .locked(lck[3]), .beat_count(beat[3]), .err_count(errc[3]),
    .err_flag(flag[3]), .first_err_exp(fexp[3]), .first_err_got(fgot[3]));

  typedef struct {
    int          inst;
    logic [31:0] beat;
    logic [31:0] err;
    logic        lock;
  } sb_t;

  sb_t sb[$];

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  logic [31:0] m_exp [4], m_beat [4], m_err [4], m_fexp [4], m_fgot [4], mask [4];
  logic        m_lock [4], m_flag [4];

  // tready[3] history from the first reset release, for LFSR alignment
  logic rec [1024];
  int   nrec = 0;
  always @(negedge aclk) begin
    if (aresetn === 1'b1 && nrec < 1024) begin
      rec[nrec] = tready[3];
      nrec      = nrec + 1;
    end
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear(input int i);
    m_exp[i] = 0; m_beat[i] = 0; m_err[i] = 0; m_fexp[i] = 0; m_fgot[i] = 0;
    m_lock[i] = 1'b0; m_flag[i] = 1'b0;
  endtask

  task automatic model_accept(input int i, input logic [31:0] din);
    logic [31:0] d;
    d = din & mask[i];
    if (m_beat[i] != 32'hFFFF_FFFF) m_beat[i] = m_beat[i] + 1;
    if (m_lock[i] && d != m_exp[i]) begin
      if (m_err[i] != 32'hFFFF_FFFF) m_err[i] = m_err[i] + 1;
      if (!m_flag[i]) begin
        m_fexp[i] = m_exp[i];
        m_fgot[i] = d;
      end
      m_flag[i] = 1'b1;
    end
    m_exp[i]  = (d + 1) & mask[i];
    m_lock[i] = 1'b1;
  endtask

  // Called at a negedge; leaves tvalid high so back-to-back sends stay continuous
  task automatic send(input int i, input logic [31:0] d);
    int  guard;
    sb_t e;
    guard     = 0;
    tdata[i]  = d;
    tvalid[i] = 1'b1;
    while (!tready[i] && guard < 200) begin
      @(negedge aclk);
      guard++;
    end
    if (!tready[i]) begin
      chk_val("handshake_timeout", {31'b0, tready[i]}, 32'd1);
      tvalid[i] = 1'b0;
      return;
    end
    model_accept(i, d);
    e.inst = i; e.beat = m_beat[i]; e.err = m_err[i]; e.lock = m_lock[i];
    sb.push_back(e);
    @(negedge aclk);
    e = sb.pop_front();
    chk_val("sb_beat", beat[e.inst], e.beat);
    chk_val("sb_err",  errc[e.inst], e.err);
    chk_val("sb_lock", {31'b0, lck[e.inst]}, {31'b0, e.lock});
  endtask

  task automatic check_clean(input string tag, input int i);
    chk_val({tag, "_beat"}, beat[i], 0);
    chk_val({tag, "_err"},  errc[i], 0);
    chk_val({tag, "_flag"}, {31'b0, flag[i]}, 0);
    chk_val({tag, "_lock"}, {31'b0, lck[i]}, 0);
    chk_val({tag, "_fexp"}, fexp[i], 0);
    chk_val({tag, "_fgot"}, fgot[i], 0);
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int          t_first, t_last, ones, found;
    logic [31:0] base;
    logic [15:0] l;
    bit          ok;

    aresetn = 1'b0;
    clr     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tdata[i] = '0; tvalid[i] = 1'b0; mask[i] = 32'hFFFF_FFFF;
      model_clear(i);
    end
    mask[1] = 32'h0000_00FF;

    repeat (3) @(negedge aclk);
    check_clean("rst", 0);
    chk_val("rst_tready", {31'b0, tready[0]}, 0);
    aresetn = 1'b1;
    repeat (4) @(negedge aclk);

    // Test 1: 0..99 on always-ready instance
    for (int d = 0; d < 100; d++) begin
      chk_val("t1_tready", {31'b0, tready[0]}, 1);
      send(0, d);
    end
    tvalid[0] = 1'b0;
    chk_val("t1_beat", beat[0], 100);
    chk_val("t1_err",  errc[0], 0);
    chk_val("t1_lock", {31'b0, lck[0]}, 1);

    // Test 2: a single skip after clr
    clr = 1'b1;
    @(negedge aclk);
    clr = 1'b0;
    model_clear(0);
    check_clean("t2_clr", 0);
    send(0, 5); send(0, 6); send(0, 7); send(0, 9); send(0, 10);
    tvalid[0] = 1'b0;
    chk_val("t2_err",  errc[0], 1);
    chk_val("t2_fexp", fexp[0], 8);
    chk_val("t2_fgot", fgot[0], 9);
    chk_val("t2_flag", {31'b0, flag[0]}, 1);
    chk_val("t2_beat", beat[0], 5);

    // Test 3: 8-bit wrap FE,FF,00,01
    send(1, 32'hFE); send(1, 32'hFF); send(1, 32'h00); send(1, 32'h01);
    tvalid[1] = 1'b0;
    chk_val("t3_err",  errc[1], 0);
    chk_val("t3_beat", beat[1], 4);
    chk_val("t3_lock", {31'b0, lck[1]}, 1);

    // Test 4: periodic ready, duty then held-valid throughput
    ones = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge aclk);
      if (tready[2]) ones++;
    end
    chk_val("t4_duty", ones, 100);
    send(2, 0);
    t_first = cyc;
    for (int d = 1; d < 1000; d++) send(2, d);
    t_last = cyc;
    tvalid[2] = 1'b0;
    chk_val("t4_cycles", t_last - t_first, 3996);
    chk_val("t4_beat",   beat[2], 1000);
    chk_val("t4_err",    errc[2], 0);

    // Test 5: LFSR ready pattern alignment, then gapped traffic across a 32-bit wrap
    chk_val("t5_rec_full", nrec, 1024);
    found = 0;
    for (int dly = 0; dly <= 6; dly++) begin
      l  = 16'hACE1;
      ok = 1'b1;
      for (int c = 0; c < 1024; c++) begin
        if (c < dly) begin
          if (rec[c] !== 1'b0) ok = 1'b0;
        end else begin
          l = lstep(l);
          if (rec[c] !== l[0]) ok = 1'b0;
        end
      end
      if (ok && found == 0) found = 1;
    end
    chk_val("t5_lfsr_seq", found, 1);
    base = 32'hFFFF_F000;
    for (int w = 0; w < 10000; w++) begin
      if ($urandom_range(3) == 0) begin
        tvalid[3] = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge aclk);
      end
      send(3, base + w);
    end
    tvalid[3] = 1'b0;
    chk_val("t5_err",  errc[3], 0);
    chk_val("t5_beat", beat[3], 10000);

    // Test 6: clr colliding with an accepted beat after errors
    send(0, 100);
    tvalid[0] = 1'b0;
    chk_val("t6_err2", errc[0], 2);
    chk_val("t6_fexp_kept", fexp[0], 8);
    chk_val("t6_clr_rdy", {31'b0, tready[0]}, 1);
    tdata[0] = 200; tvalid[0] = 1'b1; clr = 1'b1;
    @(negedge aclk);
    clr = 1'b0; tvalid[0] = 1'b0;
    model_clear(0);
    check_clean("t6_clr", 0);
    send(0, 500); send(0, 501);
    tvalid[0] = 1'b0;
    chk_val("t6_resync_beat", beat[0], 2);
    chk_val("t6_resync_err",  errc[0], 0);

    // Reset pulse mid-stream
    send(0, 7);
    tdata[0] = 8; tvalid[0] = 1'b1;
    aresetn = 1'b0;
    @(negedge aclk);
    chk_val("t6_rst_tready", {31'b0, tready[0]}, 0);
    check_clean("t6_rst", 0);
    @(negedge aclk);
    tvalid[0] = 1'b0;
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) model_clear(i);
    send(0, 1000); send(0, 1001); send(0, 1002);
    tvalid[0] = 1'b0;
    chk_val("t6_post_beat", beat[0], 3);
    chk_val("t6_post_err",  errc[0], 0);
    chk_val("t6_post_flag", {31'b0, flag[0]}, 0);
    chk_val("t6_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
